// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR constants, state encoding and step function
package lfsr_pkg;

    localparam int              LFSR_W       = 8;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h8A;
    // Feedback taps q[7], q[5], q[4], q[3]
    localparam logic [LFSR_W-1:0] TAP_MASK     = 8'hB8;

    typedef enum logic {
        WARMUP = 1'b0,
        SERVE  = 1'b1
    } state_t;

    // Fibonacci step: shift left, feedback is the XOR of the tapped bits
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - 8-bit Fibonacci LFSR register with step and load controls
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset, loads RESET_VALUE
//   step        advance the LFSR by one step
//   load        load load_value (takes priority over step)
//   load_value  value written on load
//   q           current LFSR contents
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VALUE = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_value,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (load) begin
            r_q <= load_value;
        end else if (step) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// rtl/lfsr_rng_arbiter.sv - round-robin arbiter sharing one LFSR among requesters
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   req         per-requester level request, held until its gnt pulse
//   seed_load   one-cycle pulse loading seed_value (zero maps to DEFAULT_SEED)
//   seed_value  new seed
//   gnt         one-hot grant pulse
//   rnd_data    random byte, qualified by rnd_valid
//   rnd_valid   high with the gnt pulse
//   rnd_id      index of the granted requester
//   busy        high while warming up
module lfsr_rng_arbiter #(
    parameter int         N_REQ         = 4,
    parameter logic [7:0] DEFAULT_SEED  = 8'h8A,
    parameter int         WARMUP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             seed_load,
    input  logic [7:0]       seed_value,
    output logic [N_REQ-1:0] gnt,
    output logic [7:0]       rnd_data,
    output logic             rnd_valid,
    output logic [2:0]       rnd_id,
    output logic             busy
);

    import lfsr_pkg::*;

    localparam state_t     RESET_STATE = (WARMUP_CYCLES > 0) ? WARMUP : SERVE;
    localparam logic [3:0] WARM_INIT   = 4'(WARMUP_CYCLES);
    localparam logic [N_REQ-1:0] ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_warm_cnt;
    logic [3:0]       w_warm_cnt_next;
    logic [2:0]       r_rr_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic             r_rnd_valid;
    logic [7:0]       r_rnd_data;
    logic [2:0]       r_rnd_id;

    logic [7:0]       w_lfsr_q;
    logic [7:0]       w_load_value;
    logic             w_step;
    logic             w_grant;
    logic             w_found;
    logic [2:0]       w_win;
    int               w_idx;

    assign w_load_value = (seed_value == 8'h00) ? DEFAULT_SEED : seed_value;

    lfsr_core #(
        .RESET_VALUE (DEFAULT_SEED)
    ) u_lfsr_core (
        .clk        (clk),
        .reset      (reset),
        .step       (w_step),
        .load       (seed_load),
        .load_value (w_load_value),
        .q          (w_lfsr_q)
    );

    // First set request searching upward from the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = (int'(r_rr_ptr) + i) % N_REQ;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = 3'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RESET_STATE;
            r_warm_cnt <= WARM_INIT;
        end else begin
            r_state    <= w_state_next;
            r_warm_cnt <= w_warm_cnt_next;
        end
    end

    // The grant cycle (r_rnd_valid high) is where the LFSR steps, so the value
    // captured at the decision edge is exactly what is presented. Requests seen
    // during the grant cycle are ignored, giving at most one grant per 2 cycles.
    // A reseed in the decision cycle cancels that decision; the core gives load
    // priority over step, so a reseed during the grant cycle overrides the step.
    always_comb begin
        w_state_next    = r_state;
        w_warm_cnt_next = r_warm_cnt;
        w_step          = 1'b0;
        w_grant         = 1'b0;
        busy            = (r_state == WARMUP);

        if (seed_load) begin
            w_state_next    = RESET_STATE;
            w_warm_cnt_next = WARM_INIT;
        end else begin
            case (r_state)
                WARMUP: begin
                    w_step = 1'b1;
                    if (r_warm_cnt <= 4'd1) begin
                        w_warm_cnt_next = 4'd0;
                        w_state_next    = SERVE;
                    end else begin
                        w_warm_cnt_next = r_warm_cnt - 4'd1;
                    end
                end
                SERVE: begin
                    w_step  = r_rnd_valid;
                    w_grant = w_found && !r_rnd_valid;
                end
                default: w_state_next = RESET_STATE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt       <= '0;
            r_rnd_valid <= 1'b0;
            r_rnd_data  <= 8'h00;
            r_rnd_id    <= 3'd0;
            r_rr_ptr    <= 3'd0;
        end else begin
            r_gnt       <= '0;
            r_rnd_valid <= w_grant;
            if (w_grant) begin
                r_gnt      <= ONE << w_win;
                r_rnd_data <= w_lfsr_q;
                r_rnd_id   <= w_win;
                r_rr_ptr   <= (int'(w_win) == N_REQ - 1) ? 3'd0 : w_win + 3'd1;
            end
        end
    end

    assign gnt       = r_gnt;
    assign rnd_valid = r_rnd_valid;
    assign rnd_data  = r_rnd_data;
    assign rnd_id    = r_rnd_id;

endmodule
